// File: rtl/ram2_ctrl_if.sv
// RAM2 array port bundle: the controller drives address, data and strobes,
// and the array returns combinational read data.
interface ram2_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_re;
  logic              ram_we;

  modport master (
    output ram_addr,
    output ram_wdata,
    output ram_re,
    output ram_we,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_wdata,
    input  ram_re,
    input  ram_we,
    output ram_rdata
  );
endinterface

// File: rtl/ram2_ctrl.sv
// Single-port RAM2 access controller: arbitrates IF fetches and MEM loads/stores
// onto one port. Optional RAM2_INST_BYPASS_EN forwards stores into a held if_inst.
module ram2_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_ce,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_o,
  output logic [1:0]        state_o,
  ram2_ctrl_if.master       ram
);

  typedef enum logic [1:0] {IDLE, FETCH, MEM_RD, MEM_WR} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              inst_rdy_q, inst_rdy_d;
  logic              mem_rdy_q, mem_rdy_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_re_q, ram_re_d;
  logic              ram_we_q, ram_we_d;

  logic mem_pend, if_pend;

  assign mem_pend = mem_ce & (mem_re | mem_we) & ~mem_rdy_q;
  assign if_pend  = if_req & ~inst_rdy_q;
  assign stall_o  = mem_pend | if_pend;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inst_rdy_d  = inst_rdy_q;
    mem_rdy_d   = mem_rdy_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_re_d    = ram_re_q;
    ram_we_d    = ram_we_q;

    // Pipeline advanced: results have been consumed.
    if (!stall_o) begin
      inst_rdy_d = 1'b0;
      mem_rdy_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (mem_pend) begin
          state_d     = mem_we ? MEM_WR : MEM_RD;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          ram_re_d    = ~mem_we;
          ram_we_d    = mem_we;
          cnt_d       = 3'(WAIT_CYCLES);
        end else if (if_pend) begin
          state_d    = FETCH;
          ram_addr_d = if_pc;
          ram_re_d   = 1'b1;
          cnt_d      = 3'(WAIT_CYCLES);
        end
      end
      default: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d  = IDLE;
          ram_re_d = 1'b0;
          ram_we_d = 1'b0;
          case (state_q)
            FETCH: begin
              if_inst_d  = ram.ram_rdata;
              inst_rdy_d = 1'b1;
            end
            MEM_RD: begin
              mem_rdata_d = ram.ram_rdata;
              mem_rdy_d   = 1'b1;
            end
            default: begin
              mem_rdy_d = 1'b1;
`ifdef RAM2_INST_BYPASS_EN
              // Latched store address/data equal the MEM inputs held under stall.
              if (inst_rdy_q && (ram_addr_q == if_pc)) if_inst_d = ram_wdata_q;
`endif
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      inst_rdy_q  <= 1'b0;
      mem_rdy_q   <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inst_rdy_q  <= inst_rdy_d;
      mem_rdy_q   <= mem_rdy_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign if_inst       = if_inst_q;
  assign mem_rdata     = mem_rdata_q;
  assign state_o       = state_q;
  assign ram.ram_addr  = ram_addr_q;
  assign ram.ram_wdata = ram_wdata_q;
  assign ram.ram_re    = ram_re_q;
  assign ram.ram_we    = ram_we_q;

endmodule

// File: tb/tb_ram2_ctrl.sv
// Bench for ram2_ctrl (WAIT_CYCLES=1) with a behavioural RAM2 array and a
// shadow-memory scoreboard of expected if_inst / mem_rdata.
module tb_ram2_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_inst;
  logic          mem_ce, mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_o;
  logic [1:0]    state_o;

  ram2_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_bus ();

  ram2_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_pc(if_pc), .if_inst(if_inst),
    .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_o(stall_o),
    .state_o(state_o), .ram(ram_bus)
  );

  // clock / RAM2 array
  always #5 clk = ~clk;

  logic [DW-1:0] ram_mem [0:65535];
  logic [DW-1:0] shadow  [0:65535];

  assign ram_bus.ram_rdata = ram_mem[ram_bus.ram_addr];
  always @(posedge clk) if (ram_bus.ram_we) ram_mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;

  // scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_inst, model_mdata;

  task automatic chk_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_pc = '0; mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic wait_done(output int ncyc, output int nre, output int nwe,
                           output logic [15:0] first_addr);
    ncyc = 0; nre = 0; nwe = 0; first_addr = '0;
    do begin
      @(negedge clk);
      ncyc++;
      if (ncyc == 1) first_addr = ram_bus.ram_addr;
      nre += int'(ram_bus.ram_re);
      nwe += int'(ram_bus.ram_we);
    end while (stall_o && ncyc < 40);
    if (stall_o) chk_val("stall_timeout", 16'(stall_o), 16'd0);
  endtask

  task automatic check_results(input string tag);
    logic [DW-1:0] e_inst, e_mdata;
    if (exp_q.size() < 2) begin
      chk_val({tag, "_q_empty"}, 16'(exp_q.size()), 16'd2);
    end else begin
      e_inst  = exp_q.pop_front();
      e_mdata = exp_q.pop_front();
      chk_val({tag, "_if_inst"}, if_inst, e_inst);
      chk_val({tag, "_mem_rdata"}, mem_rdata, e_mdata);
    end
  endtask

  // One request group presented at once, held until stall_o drops.
  task automatic run_req(input string tag, input logic f, input logic [15:0] pc,
                         input logic ce, input logic re, input logic we,
                         input logic [15:0] addr, input logic [15:0] wd);
    logic          mem_act;
    int            e_cyc, e_re, e_we, ncyc, nre, nwe;
    logic [15:0]   first_addr;
    mem_act = ce & (re | we);
    // MEM is always served before IF, so apply the store first.
    if (mem_act && we)  shadow[addr] = wd;
    else if (mem_act)   model_mdata = shadow[addr];
    if (f) model_inst = shadow[pc];
    exp_q.push_back(model_inst);
    exp_q.push_back(model_mdata);
    e_cyc = (f ? WC + 2 : 0) + (mem_act ? WC + 2 : 0);
    e_re  = (f ? WC + 1 : 0) + ((mem_act && !we) ? WC + 1 : 0);
    e_we  = (mem_act && we) ? WC + 1 : 0;

    @(negedge clk);
    if_req = f; if_pc = pc; mem_ce = ce; mem_re = re; mem_we = we;
    mem_addr = addr; mem_wdata = wd;
    wait_done(ncyc, nre, nwe, first_addr);
    chk_val({tag, "_cycles"}, 16'(ncyc), 16'(e_cyc));
    chk_val({tag, "_re_width"}, 16'(nre), 16'(e_re));
    chk_val({tag, "_we_width"}, 16'(nwe), 16'(e_we));
    chk_val({tag, "_ram_addr"}, first_addr, mem_act ? addr : pc);
    check_results(tag);
    if (mem_act && we) chk_val({tag, "_ram_word"}, ram_mem[addr], wd);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    int            ncyc, nre, nwe;
    logic [15:0]   fa;
    logic          f, ce, re, we;
    logic [15:0]   pc, addr, wd;

    for (int i = 0; i < 65536; i++) ram_mem[i] = 16'(i * 7 + 3);
    ram_mem[16'h0010] = 16'h6911;
    ram_mem[16'h0020] = 16'hA5A5;
    ram_mem[16'h0040] = 16'h0000;
    for (int i = 0; i < 65536; i++) shadow[i] = ram_mem[i];
    model_inst = '0; model_mdata = '0;

    // reset
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk_val("rst_if_inst", if_inst, 16'h0);
    chk_val("rst_mem_rdata", mem_rdata, 16'h0);
    chk_val("rst_strobes", {14'd0, ram_bus.ram_re, ram_bus.ram_we}, 16'h0);
    chk_val("rst_state", 16'(state_o), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_val("idle_stall", 16'(stall_o), 16'd0);

    // directed cases
    run_req("fetch10", 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    run_req("rd_and_fetch", 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
    run_req("st30", 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0030, 16'hBEEF);
    run_req("ld30", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
    run_req("rdwr31", 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0031, 16'h1234);
    run_req("ce_off", 1'b1, 16'h0031, 1'b0, 1'b1, 1'b1, 16'h0030, 16'hDEAD);
    run_req("stFFFF", 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hC0DE);
    run_req("ldFFFF", 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0);

    // reset in the middle of a store
    @(negedge clk);
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 16'h0050; mem_wdata = 16'h7777;
    @(negedge clk);
    chk_val("mid_we_high", 16'(ram_bus.ram_we), 16'd1);
    rst = 1'b1;
    #1;
    chk_val("mid_rst_we", 16'(ram_bus.ram_we), 16'd0);
    chk_val("mid_rst_addr", ram_bus.ram_addr, 16'h0);
    chk_val("mid_rst_wdata", ram_bus.ram_wdata, 16'h0);
    chk_val("mid_rst_outs", if_inst | mem_rdata, 16'h0);
    chk_val("mid_rst_state", 16'(state_o), 16'd0);
    idle_inputs();
    model_inst = '0; model_mdata = '0;
    shadow[16'h0050] = ram_mem[16'h0050];
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // store to the just-fetched address while the pipeline is stalled
    @(negedge clk);
    if_req = 1'b1; if_pc = 16'h0040;
    @(negedge clk);
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 16'h0040; mem_wdata = 16'h5A5A;
`ifdef RAM2_INST_BYPASS_EN
    model_inst = 16'h5A5A;
`else
    model_inst = shadow[16'h0040];
`endif
    shadow[16'h0040] = 16'h5A5A;
    exp_q.push_back(model_inst);
    exp_q.push_back(model_mdata);
    wait_done(ncyc, nre, nwe, fa);
    chk_val("smc_cycles", 16'(ncyc), 16'(2 * (WC + 2) - 1));
    check_results("smc");
    idle_inputs();
    @(negedge clk);

    // random traffic
    for (int n = 0; n < 24; n++) begin
      f  = 1'($urandom_range(0, 1));
      ce = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      if (!f && !(ce && (re || we))) f = 1'b1;
      pc   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h0100 + 16'($urandom_range(0, 15));
      addr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h0100 + 16'($urandom_range(0, 15));
      wd   = 16'($urandom_range(0, 65535));
      run_req("rand", f, pc, ce, re, we, addr, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
